load_store_unit: RTL and testbench

Sits between the CPU execute/memory stage and the Harvard data-memory port. Converts a load/store request into word-aligned memory transactions:
- byte-enable generation and store-data lane steering;
- after the fixed one-cycle memory read latency, extraction, sign/zero extension and LWL/LWR merging of load data.

Memory is little-endian: byte offset 0 is lane 0 (bits 7:0), offset 3 is lane 3 (bits 31:24).

---
 rtl/load_store_unit_pkg.sv | 44 ++++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/load_store_unit_align.sv | 44 ++++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared types and decode helpers for the load/store unit.
//   lsu_op_t    - 4-bit memory operation code (codes not listed are no-ops)
//   lsu_state_t - load pipeline FSM state
//   is_load / is_store / is_misaligned - operation classification helpers
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'd0,
      OP_LBU = 4'd1,
      OP_LH  = 4'd2,
      OP_LHU = 4'd3,
      OP_LW  = 4'd4,
      OP_LWL = 4'd5,
      OP_LWR = 4'd6,
      OP_SB  = 4'd8,
      OP_SH  = 4'd9,
      OP_SW  = 4'd10
   } lsu_op_t;

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } lsu_state_t;

   // Load codes occupy 0..6; 7 is a no-op.
   function automatic logic is_load(input logic [3:0] op);
      return (op < 4'd7);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Halfword ops need an even address, word ops a word-aligned one;
   // byte ops and LWL/LWR can never fault.
   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
      logic half_op;
      logic word_op;
      half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word_op = (op == OP_LW) || (op == OP_SW);
      return (half_op && off[0]) || (word_op && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the CPU-side request/response and the
// Harvard data-memory port of the load/store unit.
//   CPU side   : mem_req, mem_op, addr, store_data, rt_old (requests)
//                load_result, load_valid, addr_error     (responses)
//   Memory side: data_address, data_read, data_write, byteenable,
//                data_writedata (to memory), data_readdata (from memory)
//   slave modport  - the load/store unit itself
//   master modport - the CPU/memory environment driving it
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_req;
   logic [3:0]        mem_op;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       store_data;
   logic [31:0]       rt_old;
   logic [ADDR_W-1:0] data_address;
   logic              data_read;
   logic              data_write;
   logic [3:0]        byteenable;
   logic [31:0]       data_writedata;
   logic [31:0]       data_readdata;
   logic [31:0]       load_result;
   logic              load_valid;
   logic              addr_error;

   modport slave (
      input  mem_req, mem_op, addr, store_data, rt_old, data_readdata,
      output data_address, data_read, data_write, byteenable, data_writedata,
             load_result, load_valid, addr_error
   );

   modport master (
      output mem_req, mem_op, addr, store_data, rt_old, data_readdata,
      input  data_address, data_read, data_write, byteenable, data_writedata,
             load_result, load_valid, addr_error
   );
endinterface

// File: rtl/load_store_unit_align.sv
// load_align: combinational load data alignment.
//   op     in  4   captured load operation
//   k      in  2   captured byte offset addr[1:0]
//   mem    in  32  word returned by memory (little-endian lanes)
//   rt     in  32  captured rt value for LWL/LWR merge
//   result out 32  extracted / extended / merged load value
module load_align
   import lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  k,
   input  logic [31:0] mem,
   input  logic [31:0] rt,
   output logic [31:0] result
);

   logic [4:0]  lane_shift;
   logic [31:0] mem_down;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      lane_shift = {k, 3'b000};
      // Byte k moved down to lane 0; also the LWR memory contribution.
      mem_down   = mem >> lane_shift;
      byte_v     = mem_down[7:0];
      half_v     = k[1] ? mem[31:16] : mem[15:0];
      result     = '0;
      case (lsu_op_t'(op))
         OP_LB:   result = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  result = {24'd0, byte_v};
         OP_LH:   result = {{16{half_v[15]}}, half_v};
         OP_LHU:  result = {16'd0, half_v};
         OP_LW:   result = mem;
         // Bytes k..0 shifted to the top (shift by 3-k lanes); rt keeps the
         // low 3-k bytes.
         OP_LWL:  result = (mem << {~k, 3'b000}) | (rt & (32'h00FF_FFFF >> lane_shift));
         // Bytes 3..k shifted to the bottom; rt keeps the top k bytes.
         OP_LWR:  result = mem_down | (rt & ~(32'hFFFF_FFFF >> lane_shift));
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts CPU load/store requests into word-aligned
// data-memory transactions and aligns returning load data.
//   clk    in  1   clock, all state on posedge
//   reset  in  1   synchronous active-high reset
//   bus    slave modport of load_store_unit_if (request, memory port,
//          load response, address error)
// Stores issue with zero latency; loads return one cycle after acceptance
// and may be issued back to back.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   load_store_unit_if.slave       bus
);

   lsu_state_t  state_q, state_d;
   logic [3:0]  ctx_op_q;
   logic [1:0]  ctx_k_q;
   logic [31:0] ctx_rt_q;

   logic [3:0]  op;
   logic [1:0]  k;
   logic [4:0]  lane_shift;
   logic        err;
   logic        accept_ld;
   logic        accept_st;
   logic [31:0] aligned_result;

   // Request decode
   always_comb begin
      op         = bus.mem_op;
      k          = bus.addr[1:0];
      lane_shift = {k, 3'b000};
      err        = bus.mem_req && is_misaligned(op, k);
      accept_ld  = bus.mem_req && is_load(op) && !err;
      accept_st  = bus.mem_req && is_store(op) && !err;
   end

   // Request-cycle memory strobes and store steering
   always_comb begin
      bus.data_address   = '0;
      bus.data_read      = 1'b0;
      bus.data_write     = 1'b0;
      bus.byteenable     = '0;
      bus.data_writedata = '0;
      bus.addr_error     = err;
      if (bus.mem_req) begin
         bus.data_address = {bus.addr[ADDR_W-1:2], 2'b00};
      end
      if (accept_ld) begin
         bus.data_read  = 1'b1;
         bus.byteenable = 4'b1111;
      end
      if (accept_st) begin
         bus.data_write = 1'b1;
         case (lsu_op_t'(op))
            OP_SB: begin
               bus.byteenable     = 4'b0001 << k;
               bus.data_writedata = {24'd0, bus.store_data[7:0]} << lane_shift;
            end
            OP_SH: begin
               bus.byteenable     = 4'b0011 << k;
               bus.data_writedata = {16'd0, bus.store_data[15:0]} << lane_shift;
            end
            default: begin
               bus.byteenable     = 4'b1111;
               bus.data_writedata = bus.store_data;
            end
         endcase
      end
   end

   // FSM state and captured load context
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ctx_op_q <= '0;
         ctx_k_q  <= '0;
         ctx_rt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_ld) begin
            ctx_op_q <= op;
            ctx_k_q  <= k;
            ctx_rt_q <= bus.rt_old;
         end
      end
   end

   always_comb begin
      state_d        = IDLE;
      bus.load_valid = 1'b0;
      bus.load_result = '0;
      case (state_q)
         IDLE: begin
            if (accept_ld) state_d = LOAD_WAIT;
         end
         LOAD_WAIT: begin
            bus.load_valid  = 1'b1;
            bus.load_result = aligned_result;
            if (accept_ld) state_d = LOAD_WAIT;
         end
         default: state_d = IDLE;
      endcase
   end

   load_align u_align (
      .op     (ctx_op_q),
      .k      (ctx_k_q),
      .mem    (bus.data_readdata),
      .rt     (ctx_rt_q),
      .result (aligned_result)
   );

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. A driver issues
// directed and random requests and queues expected request-cycle strobes and
// expected load results (from a byte-array memory model); a negedge monitor
// pops and compares. A small word memory answers the DUT's port.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam logic [31:0] BASE = 32'hBFC0_0000;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        err;
      logic [3:0]  be;
      logic        chk_addr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] wmask;
   } req_exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } ld_exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   req_exp_t req_q[$];
   ld_exp_t  ld_q[$];
   logic [31:0] mem_w [16];
   logic [7:0]  ref_b [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   load_store_unit_if #(.ADDR_W(32)) bus();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Data memory: one-cycle read latency, byte-enabled writes.
   always @(posedge clk) begin
      if (bus.data_write)
         for (int i = 0; i < 4; i++)
            if (bus.byteenable[i])
               mem_w[bus.data_address[5:2]][8*i +: 8] <= bus.data_writedata[8*i +: 8];
      if (bus.data_read)
         bus.data_readdata <= mem_w[bus.data_address[5:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model over a byte-addressed memory image.
   function automatic logic model_misaligned(input logic [3:0] op, input int off);
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return (off % 2) != 0;
      if (op == OP_LW || op == OP_SW) return (off % 4) != 0;
      return 1'b0;
   endfunction

   function automatic int store_size(input logic [3:0] op);
      if (op == OP_SB) return 1;
      if (op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [3:0] op, input int off, input logic [31:0] rt);
      int w;
      int k;
      logic [31:0] r;
      logic [7:0]  b;
      logic [15:0] h;
      w = off - (off % 4);
      k = off % 4;
      r = rt;
      b = ref_b[off];
      case (op)
         OP_LB:  r = {{24{b[7]}}, b};
         OP_LBU: r = {24'd0, b};
         OP_LH:  begin h = {ref_b[off+1], ref_b[off]}; r = {{16{h[15]}}, h}; end
         OP_LHU: begin h = {ref_b[off+1], ref_b[off]}; r = {16'd0, h}; end
         OP_LW:  r = {ref_b[off+3], ref_b[off+2], ref_b[off+1], ref_b[off]};
         OP_LWL: for (int j = 0; j <= k; j++) r[8*(3-j) +: 8] = ref_b[w+k-j];
         OP_LWR: for (int j = 0; j <= 3 - k; j++) r[8*j +: 8] = ref_b[w+k+j];
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic idle(input logic rst);
      req_exp_t e;
      @(posedge clk); #1;
      reset          = rst;
      bus.mem_req    = 1'b0;
      bus.mem_op     = 4'($urandom_range(0, 15));
      bus.addr       = $urandom;
      bus.store_data = $urandom;
      bus.rt_old     = $urandom;
      e = '{rd: 1'b0, wr: 1'b0, err: 1'b0, be: 4'd0, chk_addr: 1'b1,
            addr: 32'd0, wd: 32'd0, wmask: 32'hFFFF_FFFF};
      req_q.push_back(e);
   endtask

   task automatic issue(input logic [3:0] op, input int off, input logic [31:0] sd,
                        input logic [31:0] rt, input logic use_exp,
                        input logic [31:0] exp_val, input logic rst);
      req_exp_t e;
      ld_exp_t  l;
      int       k;
      logic     ld;
      logic     st;
      @(posedge clk); #1;
      reset          = rst;
      bus.mem_req    = 1'b1;
      bus.mem_op     = op;
      bus.addr       = BASE + 32'(off);
      bus.store_data = sd;
      bus.rt_old     = rt;
      k  = off % 4;
      ld = (op <= 4'd6);
      st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
      e.err      = (ld || st) && model_misaligned(op, off);
      e.rd       = ld && !e.err;
      e.wr       = st && !e.err;
      e.chk_addr = e.rd || e.wr;
      e.addr     = BASE + 32'(off - k);
      e.be       = e.rd ? 4'b1111 : 4'b0000;
      e.wd       = '0;
      e.wmask    = '0;
      if (e.wr)
         for (int j = 0; j < store_size(op); j++) begin
            e.be[k+j]           = 1'b1;
            e.wd[8*(k+j) +: 8]  = sd[8*j +: 8];
            e.wmask[8*(k+j) +: 8] = 8'hFF;
         end
      req_q.push_back(e);
      if (e.rd && !rst) begin
         l.cyc = cyc + 1;
         l.val = use_exp ? exp_val : model_load(op, off, rt);
         ld_q.push_back(l);
      end
      if (e.wr && !rst)
         for (int j = 0; j < store_size(op); j++) ref_b[off+j] = sd[8*j +: 8];
   endtask

   // Monitor: compares every cycle away from the clock edge.
   always @(negedge clk) begin
      req_exp_t e;
      ld_exp_t  l;
      if (req_q.size() > 0) begin
         e = req_q.pop_front();
         check("data_read",   {31'd0, bus.data_read},  {31'd0, e.rd});
         check("data_write",  {31'd0, bus.data_write}, {31'd0, e.wr});
         check("addr_error",  {31'd0, bus.addr_error}, {31'd0, e.err});
         check("byteenable",  {28'd0, bus.byteenable}, {28'd0, e.be});
         if (e.chk_addr) check("data_address", bus.data_address, e.addr);
         if (e.wmask != 0) check("data_writedata", bus.data_writedata & e.wmask, e.wd);
      end
      if (bus.load_valid === 1'b1) begin
         if (ld_q.size() == 0) begin
            check("load_valid_unexpected", {31'd0, bus.load_valid}, 32'd0);
         end else begin
            l = ld_q.pop_front();
            check("load_latency", 32'(cyc), 32'(l.cyc));
            check("load_result", bus.load_result, l.val);
         end
      end else begin
         check("load_result_idle", bus.load_result, 32'd0);
         if (ld_q.size() > 0 && ld_q[0].cyc <= cyc) begin
            check("load_valid_missing", {31'd0, bus.load_valid}, 32'd1);
            void'(ld_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      reset          = 1'b1;
      bus.mem_req    = 1'b0;
      bus.mem_op     = '0;
      bus.addr       = '0;
      bus.store_data = '0;
      bus.rt_old     = '0;
      for (int i = 0; i < 16; i++) begin
         w = (i == 4) ? 32'h8899_AABB : $urandom;
         mem_w[i] = w;
         for (int j = 0; j < 4; j++) ref_b[4*i+j] = w[8*j +: 8];
      end

      repeat (3) idle(1'b1);
      idle(1'b0);

      // Directed test plan (word at offset 0x10 = 0x8899AABB)
      issue(OP_LB,  'h13, 0, 0, 1'b1, 32'hFFFF_FF88, 1'b0);
      issue(OP_LBU, 'h12, 0, 0, 1'b1, 32'h0000_0099, 1'b0);
      issue(OP_LH,  'h12, 0, 0, 1'b1, 32'hFFFF_8899, 1'b0);
      issue(OP_LHU, 'h10, 0, 0, 1'b1, 32'h0000_AABB, 1'b0);
      issue(OP_LWL, 'h11, 0, 32'h1122_3344, 1'b1, 32'hAABB_3344, 1'b0);
      issue(OP_LWR, 'h12, 0, 32'h1122_3344, 1'b1, 32'h1122_8899, 1'b0);
      issue(OP_SB,  'h11, 32'h0000_00CC, 0, 1'b0, 0, 1'b0);
      issue(OP_LW,  'h10, 0, 0, 1'b1, 32'h8899_CCBB, 1'b0);
      issue(OP_LW,  'h12, 0, 0, 1'b0, 0, 1'b0);
      issue(OP_SH,  'h11, 32'h1234_5678, 0, 1'b0, 0, 1'b0);
      issue(4'd7,   'h10, 0, 0, 1'b0, 0, 1'b0);
      issue(4'd15,  'h10, 0, 0, 1'b0, 0, 1'b0);
      idle(1'b0);

      // Load accepted, then reset cycle with a second (ignored) load request
      issue(OP_LW, 'h10, 0, 0, 1'b0, 0, 1'b0);
      issue(OP_LW, 'h14, 0, 0, 1'b0, 0, 1'b1);
      idle(1'b0);
      idle(1'b0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) < 2)
            idle(1'b0);
         else
            issue(4'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
                  $urandom, $urandom, 1'b0, 0, 1'b0);
      end

      repeat (3) idle(1'b0);
      @(posedge clk); #1;
      check("pending_loads_drained", 32'(ld_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
